// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-add/subtract multiplier controller and its bench.
package multiplier_pkg;

    localparam int N_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/multiplier_ctrl.sv
// Sequencer for the 8-bit signed shift-add/subtract multiplier: clears X:A, runs
// N_BITS add/shift iterations (subtracting on the last), then holds until run drops.
module multiplier_ctrl
    import multiplier_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic load_b,
    input  logic clear_a,
    input  logic m,
    output logic ld_b,
    output logic clr_xa,
    output logic ld_xa,
    output logic sub_add,
    output logic shift,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(N_BITS);
    localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

    ctrl_state_t   r_state;
    ctrl_state_t   w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_run_q;
    logic          r_armed;
    logic          w_start;

    assign w_start = run & ~r_run_q;

    // r_armed keeps every strobe quiet in the first cycle after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_run_q <= 1'b1;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_run_q <= run;
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        ld_b       = 1'b0;
        clr_xa     = 1'b0;
        ld_xa      = 1'b0;
        sub_add    = 1'b0;
        shift      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = CLR;
                end else begin
                    ld_b   = load_b;
                    clr_xa = clear_a;
                end
            end
            CLR: begin
                clr_xa     = 1'b1;
                busy       = 1'b1;
                w_cnt_next = '0;
                w_next     = ADD;
            end
            ADD: begin
                busy    = 1'b1;
                ld_xa   = m;
                sub_add = (r_cnt != LAST);
                w_next  = SHIFT;
            end
            SHIFT: begin
                shift = 1'b1;
                busy  = 1'b1;
                if (r_cnt == LAST) begin
                    w_next = HOLD;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                    w_next     = ADD;
                end
            end
            HOLD: begin
                done = 1'b1;
                if (!run) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (!r_armed) begin
            ld_b    = 1'b0;
            clr_xa  = 1'b0;
            ld_xa   = 1'b0;
            sub_add = 1'b0;
            shift   = 1'b0;
            busy    = 1'b0;
            done    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multiplier_ctrl.sv
// Bench for multiplier_ctrl: cycle-accurate output schedule model plus a small
// X:A:B datapath whose final product is compared with plain signed multiplication.
module tb_multiplier_ctrl;
    import multiplier_pkg::*;

    localparam int N = N_BITS_DEFAULT;
    localparam int HOLD_PH = 2 * N + 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic run = 1'b0;
    logic load_b = 1'b0;
    logic clear_a = 1'b0;
    logic m;
    logic ld_b, clr_xa, ld_xa, sub_add, shift, busy, done;

    always #5 clk = ~clk;

    multiplier_ctrl #(.N_BITS(N)) dut (
        .clk(clk), .reset(reset), .run(run), .load_b(load_b), .clear_a(clear_a),
        .m(m), .ld_b(ld_b), .clr_xa(clr_xa), .ld_xa(ld_xa), .sub_add(sub_add),
        .shift(shift), .busy(busy), .done(done)
    );

    // Datapath driven by the controller strobes
    logic       dp_x = 1'b0;
    logic [7:0] dp_a = 8'h00;
    logic [7:0] dp_b = 8'h00;
    logic [7:0] dp_s = 8'h00;
    logic [7:0] sw   = 8'h00;
    logic [8:0] dp_sum;

    assign m = dp_b[0];
    assign dp_sum = sub_add ? ({dp_a[7], dp_a} + {dp_s[7], dp_s})
                            : ({dp_a[7], dp_a} - {dp_s[7], dp_s});

    always @(posedge clk) begin
        if (ld_b) dp_b <= sw;
        if (clr_xa) begin
            dp_x <= 1'b0;
            dp_a <= 8'h00;
        end else if (ld_xa) begin
            dp_x <= dp_sum[8];
            dp_a <= dp_sum[7:0];
        end else if (shift) begin
            dp_a <= {dp_x, dp_a[7:1]};
            dp_b <= {dp_a[0], dp_b[7:1]};
        end
    end

    // Reference model: phase 0 idle, 1 clear, 2..2N+1 add/shift pairs, 2N+2 hold
    int   phase = 0;
    logic runp  = 1'b1;
    logic armed = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   shift_seen = 0;
    logic done_seen = 1'b0;
    int   done_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_out();
        logic start;
        logic [6:0] o;
        start = run & ~runp;
        o = 7'b0;
        if (reset || !armed) return 7'b0;
        if (phase == 0) begin
            if (!start) o = {load_b, clear_a, 5'b0};
        end else if (phase == 1) begin
            o = 7'b0100010;
        end else if (phase == HOLD_PH) begin
            o = 7'b0000001;
        end else if (phase % 2 == 0) begin
            o = {2'b00, m, (phase != 2 * N), 1'b0, 1'b1, 1'b0};
        end else begin
            o = 7'b0000110;
        end
        return o;
    endfunction

    task automatic model_update();
        if (reset) begin
            phase = 0;
            runp  = 1'b1;
            armed = 1'b0;
        end else begin
            if (phase == 0 && run && !runp) phase = 1;
            else if (phase >= 1 && phase < HOLD_PH) phase++;
            else if (phase == HOLD_PH && !run) phase = 0;
            runp  = run;
            armed = 1'b1;
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_eq(tag, {25'b0, ld_b, clr_xa, ld_xa, sub_add, shift, busy, done}, {25'b0, exp_out()});
        if (shift) shift_seen++;
        if (done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input bit rnd);
        logic signed [15:0] prod;
        int start_cyc;
        prod = $signed(a) * $signed(b);
        dp_s = a;
        sw = b;
        load_b = 1'b1;
        clear_a = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        run = 1'b0;
        cycle("idle_load");
        load_b = 1'b0;
        clear_a = 1'b0;
        run = 1'b1;
        start_cyc = cyc;
        shift_seen = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 60 && !done_seen; i++) begin
            cycle("seq");
            if (rnd && i < 2 * N) begin
                load_b  = 1'($urandom_range(0, 1));
                clear_a = 1'($urandom_range(0, 1));
                sw      = 8'($urandom);
                run     = (i < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                load_b  = 1'b0;
                clear_a = 1'b0;
                run     = 1'b1;
            end
        end
        check_eq("latency", done_cyc - start_cyc, HOLD_PH);
        check_eq("shifts", shift_seen, N);
        check_eq("product", {16'b0, dp_a, dp_b}, {16'b0, prod});
        repeat (5) cycle("hold");
        check_eq("hold_done", {31'b0, done}, 32'd1);
        run = 1'b0;
        cycle("hold_exit");
        cycle("back_idle");
        check_eq("idle_done", {31'b0, done}, 32'd0);
    endtask

    initial begin
        run = 1'b1;
        load_b = 1'b1;
        #1 reset = 1'b1;
        repeat (3) cycle("in_reset");
        reset = 1'b0;
        repeat (4) cycle("post_reset");
        check_eq("no_restart", {30'b0, busy, clr_xa}, 32'd0);
        load_b = 1'b0;
        run = 1'b0;
        cycle("idle");

        run_mult(8'h07, 8'hFD, 1'b0);
        run_mult(8'h35, 8'hCD, 1'b0);
        run_mult(8'h5A, 8'hFF, 1'b0);
        run_mult(8'h7F, 8'h00, 1'b0);
        run_mult(8'h80, 8'h80, 1'b0);
        for (int t = 0; t < 8; t++) run_mult(8'($urandom), 8'($urandom), 1'b1);

        // Reset in the middle of a multiply, run still high afterwards
        dp_s = 8'h11;
        sw = 8'h9B;
        load_b = 1'b1;
        cycle("idle_load");
        load_b = 1'b0;
        run = 1'b1;
        repeat (9) cycle("pre_abort");
        reset = 1'b1;
        #1;
        check_eq("async_reset", {25'b0, ld_b, clr_xa, ld_xa, sub_add, shift, busy, done}, 32'd0);
        cycle("abort_reset");
        reset = 1'b0;
        repeat (5) cycle("after_abort");
        check_eq("abort_idle", {30'b0, busy, done}, 32'd0);
        load_b = 1'b1;
        #1;
        check_eq("idle_ldb", {31'b0, ld_b}, 32'd1);
        cycle("idle_ldb_cyc");
        load_b = 1'b0;
        run = 1'b0;
        cycle("idle");
        run_mult(8'hC3, 8'h3C, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
